// File: rtl/mips32_pipe_pkg.sv
// Shared pipeline definitions for the MIPS32 core: register index type,
// default index width and the issue-to-writeback latency classes.
package mips32_pipe_pkg;

    localparam int DEFAULT_RADDR_W = 5;

    localparam int LAT_ALU   = 3;
    localparam int LAT_LOAD  = 4;
    localparam int LAT_STORE = 0;

    typedef logic [DEFAULT_RADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/mips32_sb_counter.sv
// One scoreboard entry: a loadable down-counter holding the number of cycles
// until the register's pending result is written back.
module mips32_sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] count,
    output logic             busy
);

    // A new write reservation overrides the countdown; otherwise count down to zero and hold
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// Register scoreboard and issue interlock: stalls an instruction whose sources
// are still in flight (RAW) or whose destination would be overwritten out of
// order (WAW), and counts stalled cycles for performance analysis.
module mips32_hazard_scoreboard
    import mips32_pipe_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RADDR_W = DEFAULT_RADDR_W,
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = 3,
    parameter int FWD_EN  = 0
) (
    input  logic               clk1,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [RADDR_W-1:0] issue_rs,
    input  logic [RADDR_W-1:0] issue_rt,
    input  logic               issue_use_rs,
    input  logic               issue_use_rt,
    input  logic               issue_wr_en,
    input  logic [RADDR_W-1:0] issue_rd,
    input  logic [LAT_W-1:0]   issue_lat,
    output logic               stall,
    output logic               issue_accept,
    output logic [NREG-1:0]    busy_vec,
    output logic [15:0]        stall_cycles
);

    localparam int NIDX = 2 ** RADDR_W;

    // With forwarding, a result one cycle from writeback is already usable
    localparam logic [LAT_W-1:0] THR   = (FWD_EN != 0) ? LAT_W'(1) : '0;
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

    // Covers every encodable index so lookups never go out of range; R0 and
    // indices beyond NREG read as permanently zero
    logic [LAT_W-1:0] counts [NIDX];
    logic [LAT_W-1:0] eff_lat;
    logic             rs_pending;
    logic             rt_pending;
    logic             waw;
    logic             load_en;

    assign eff_lat    = (issue_lat > MAX_L) ? MAX_L : issue_lat;

    assign rs_pending = issue_use_rs && (issue_rs != '0) && (counts[issue_rs] > THR);
    assign rt_pending = issue_use_rt && (issue_rt != '0) && (counts[issue_rt] > THR);
    assign waw        = issue_wr_en && (issue_rd != '0) && (counts[issue_rd] > eff_lat);

    assign stall        = issue_valid && (rs_pending || rt_pending || waw);
    assign issue_accept = issue_valid && !stall;

    // Zero-latency writes (stores) reserve nothing
    assign load_en = issue_accept && issue_wr_en && (eff_lat != '0);

    assign busy_vec[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < NIDX; i++) begin : g_reg
            if (i >= 1 && i < NREG) begin : g_track
                mips32_sb_counter #(
                    .LAT_W (LAT_W)
                ) u_cnt (
                    .clk1     (clk1),
                    .reset    (reset),
                    .load     (load_en && (issue_rd == RADDR_W'(i))),
                    .load_val (eff_lat),
                    .count    (counts[i]),
                    .busy     (busy_vec[i])
                );
            end else begin : g_zero
                assign counts[i] = '0;
            end
        end
    endgenerate

    // Saturating count of cycles in which issue was held
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: doc/mips32_hazard_scoreboard.md
# mips32_hazard_scoreboard

Register scoreboard and interlock for the pipelined MIPS32 core. It tracks in-flight register writes with a per-register countdown. It stalls the issue stage when an instruction would read or overwrite a register whose result is not yet available. This replaces the dummy `OR R3,R3,R3` padding currently needed between dependent instructions. The block is parametrised in register count, maximum result latency and forwarding mode, and it keeps a saturating stall-cycle counter for performance analysis.

## Interface
- `NREG`, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- `RADDR_W`, 5, register index width; `2**RADDR_W >= NREG`.
- `MAX_LAT`, 4, largest issue-to-writeback latency in cycles.
- `LAT_W`, 3, width of latency/counter fields; `2**LAT_W > MAX_LAT`.
- `FWD_EN`, 0, 1 = forwarding present, so a result is usable one cycle before writeback completes.
- `clk1` input 1 — the single clock, rising edge.
- `reset` input 1 — asynchronous, active-high.
- `issue_valid` input 1 — an instruction is presented for issue.
- `issue_rs`, `issue_rt` input RADDR_W — source register indices.
- `issue_use_rs`, `issue_use_rt` input 1 — the corresponding source is actually read.
- `issue_wr_en` input 1 — the instruction writes `issue_rd`.
- `issue_rd` input RADDR_W — destination register index.
- `issue_lat` input LAT_W — cycles until the result is written.
- `stall` output 1 — combinational; the issue stage must hold.
- `issue_accept` output 1 — combinational; equals `issue_valid & ~stall`.
- `busy_vec` output NREG — registered; bit i = counter[i] != 0.
- `stall_cycles` output 16 — registered saturating count of stalled cycles.

## Operation
- State: one LAT_W counter per register 1..NREG-1. Counter 0 is constant 0.
- Ready threshold `THR` = `FWD_EN ? 1 : 0`. A source is pending if it is used, its index is nonzero, and its counter > THR.
- WAW hazard: `issue_wr_en`, `issue_rd != 0`, and counter[rd] > effective lat.
- `stall` = `issue_valid & (rs pending | rt pending | WAW)`. `stall` is 0 whenever `issue_valid` = 0.
- Effective lat = `min(issue_lat, MAX_LAT)`.
- On accept with write enabled, rd != 0 and effective lat > 0: counter[rd] is set to the effective lat. Lat 0 leaves the counter unchanged.
- Every other nonzero counter decrements by 1 per cycle. Zero counters hold.
- Same-cycle accept and decrement on the same register: the load wins.
- Writes to R0 are never tracked. Reads of R0 never stall.
- `stall_cycles` increments on each cycle with `stall` = 1 and saturates at 16'hFFFF.

## Timing
- Reset values: all counters 0, `busy_vec` = 0, `stall_cycles` = 0. With `issue_valid` = 0, `stall` and `issue_accept` are 0.
- Reset asserted mid-operation clears all pending state immediately. The first cycle after deassertion sees an empty scoreboard.
- Sequence: accept at edge t gives counter = L in cycle t+1, then L-1, …, reaching 0 in cycle t+L+1.
- A dependent instruction presented in cycle t+1 stalls L cycles when `FWD_EN` = 0, and L-1 cycles when `FWD_EN` = 1.
- `busy_vec` reflects the accept one cycle later. No combinational path exists from `issue_*` to `busy_vec` or `stall_cycles`.

## Structure
- Shared package `mips32_pipe_pkg` holds:
  - latency-class constants `LAT_ALU` = 3, `LAT_LOAD` = 4, `LAT_STORE` = 0;
  - the `RADDR_W` default;
  - a `reg_idx_t` typedef.
- Sub-module `mips32_sb_counter`: one loadable down-counter with asynchronous reset. It is generated for registers 1..NREG-1 and exposes `count` and `busy`.
- The top level holds only the hazard compare logic, the `stall_cycles` counter and the generate loop.

## Test plan
- Reset mid-stream: counters at 3/2 when `reset` pulses → `busy_vec` = 0 at once, `stall_cycles` = 0, and the next dependent issue is accepted with no stall.
- RAW, `FWD_EN` = 0: ADDI rd=1 lat=3 accepted, then LW rs=1 presented the next cycle → exactly 3 stall cycles, accepted on the 4th, `stall_cycles` = 3.
- RAW, `FWD_EN` = 1: same stimulus → 2 stall cycles. LW rd=2 lat=4, then ADDI rs=2 → 3 stall cycles.
- R0 and unused sources:
  - write to rd=0 lat=4 → `busy_vec` stays 0;
  - read of rs=0 never stalls;
  - rt=5 busy with `issue_use_rt` = 0 → no stall.
- WAW and simultaneous load/decrement:
  - rd=7 pending count 4, issue rd=7 lat=3 → stall until count ≤ 3, then accept reloads counter[7] = 3 that same edge;
  - `issue_lat` = 7 with `MAX_LAT` = 4 → counter loads 4.
- Saturation: hold a permanently stalled issue for 70000 cycles → `stall_cycles` = 16'hFFFF and it stays there.
